// File: rtl/br_pkg.sv
// br_pkg: shared encodings for the branch controller.
// Holds the br_type encodings, the ARM condition-code constants and the FSM state encoding.
package br_pkg;
  typedef enum logic [1:0] {
    BR_B   = 2'b00,
    BR_BCC = 2'b01,
    BR_BL  = 2'b10,
    BR_BX  = 2'b11
  } br_type_e;
  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4;
  localparam logic [3:0] CC_PL = 4'h5;
  localparam logic [3:0] CC_VS = 4'h6;
  localparam logic [3:0] CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8;
  localparam logic [3:0] CC_LS = 4'h9;
  localparam logic [3:0] CC_GE = 4'hA;
  localparam logic [3:0] CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC;
  localparam logic [3:0] CC_LE = 4'hD;
  localparam logic [3:0] CC_AL = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;
  typedef enum logic [2:0] {
    S_IDLE,
    S_EVAL,
    S_LINK,
    S_WRPC,
    S_FLUSH,
    S_DONE
  } state_e;
endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational ARM condition-code check.
// Ports: cond (4-bit condition code), nzcv ({N,Z,C,V} flags) -> pass (condition holds).
module cond_eval
  import br_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);
  logic n, z, c, v, base;
  assign {n, z, c, v} = nzcv;
  // Codes come in pairs: even code tests a predicate, the odd one its inverse.
  // The 111x pair gives AL (always) and NV (never).
  always_comb begin
    base = cond[3:1] == CC_EQ[3:1] ? z :
           cond[3:1] == CC_CS[3:1] ? c :
           cond[3:1] == CC_MI[3:1] ? n :
           cond[3:1] == CC_VS[3:1] ? v :
           cond[3:1] == CC_HI[3:1] ? c & ~z :
           cond[3:1] == CC_GE[3:1] ? n == v :
           cond[3:1] == CC_GT[3:1] ? ~z & (n == v) : 1'b1;
    pass = base ^ cond[0];
  end
endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: multi-cycle branch controller (evaluate, link, PC write, flush, retire).
// Ports: clk/rst_n (async active-low); req_valid/req_ready handshake with br_type, cond,
// flags_nzcv, offset, rm_val, cur_pc captured at accept; pc_wr_en/pc_wr_data and
// lr_wr_en/lr_wr_data one-cycle write strobes; flush held FLUSH_CYCLES cycles;
// done pulse with taken and fault qualifiers.
module branch_ctrl
  import br_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  br_type,
  input  logic [3:0]  cond,
  input  logic [3:0]  flags_nzcv,
  input  logic [31:0] offset,
  input  logic [31:0] rm_val,
  input  logic [31:0] cur_pc,
  output logic        pc_wr_en,
  output logic [31:0] pc_wr_data,
  output logic        lr_wr_en,
  output logic [31:0] lr_wr_data,
  output logic        flush,
  output logic        done,
  output logic        taken,
  output logic        fault
);
  state_e      state;
  br_type_e    typ;
  logic [3:0]  cc, fl;
  logic [31:0] off, rm, pc, target;
  logic [2:0]  cnt;
  logic        pass, tk, flt;
  cond_eval u_cond (.cond(cc), .nzcv(fl), .pass(pass));
  assign target = (typ == BR_BX ? rm : pc + off) & ~32'h1;
  assign req_ready = state == S_IDLE;
  // Each output is registered from the state it belongs to, so it appears one cycle after that state is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      typ        <= BR_B;
      cc         <= '0;
      fl         <= '0;
      off        <= '0;
      rm         <= '0;
      pc         <= '0;
      cnt        <= '0;
      tk         <= 1'b0;
      flt        <= 1'b0;
      pc_wr_en   <= 1'b0;
      pc_wr_data <= '0;
      lr_wr_en   <= 1'b0;
      lr_wr_data <= '0;
      flush      <= 1'b0;
      done       <= 1'b0;
      taken      <= 1'b0;
      fault      <= 1'b0;
    end else begin
      pc_wr_en <= 1'b0;
      lr_wr_en <= 1'b0;
      flush    <= 1'b0;
      done     <= 1'b0;
      taken    <= 1'b0;
      fault    <= 1'b0;
      case (state)
        S_IDLE: if (req_valid) begin
          typ   <= br_type_e'(br_type);
          cc    <= cond;
          fl    <= flags_nzcv;
          off   <= offset;
          rm    <= rm_val;
          pc    <= cur_pc;
          state <= S_EVAL;
        end
        S_EVAL: begin
          tk    <= typ != BR_BCC || pass;
          flt   <= typ == BR_BX && !rm[0];
          state <= (typ == BR_BCC && !pass) || (typ == BR_BX && !rm[0]) ? S_DONE :
                   typ == BR_BL ? S_LINK : S_WRPC;
        end
        S_LINK: begin
          lr_wr_en   <= 1'b1;
          lr_wr_data <= pc | 32'h1;
          state      <= S_WRPC;
        end
        S_WRPC: begin
          pc_wr_en   <= 1'b1;
          pc_wr_data <= target;
          cnt        <= 3'(FLUSH_CYCLES);
          state      <= S_FLUSH;
        end
        S_FLUSH: begin
          flush <= 1'b1;
          cnt   <= cnt - 3'd1;
          if (cnt == 3'd1) state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b1;
          taken <= tk;
          fault <= flt;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: self-checking bench for branch_ctrl against a transaction-level reference model.
module tb_branch_ctrl;
  localparam int F = 2;
  logic        clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_ready;
  logic [1:0]  br_type = '0;
  logic [3:0]  cond = '0, flags_nzcv = '0;
  logic [31:0] offset = '0, rm_val = '0, cur_pc = '0;
  logic        pc_wr_en, lr_wr_en, flush, done, taken, fault;
  logic [31:0] pc_wr_data, lr_wr_data;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  branch_ctrl #(.FLUSH_CYCLES(F)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .br_type(br_type), .cond(cond), .flags_nzcv(flags_nzcv), .offset(offset),
    .rm_val(rm_val), .cur_pc(cur_pc), .pc_wr_en(pc_wr_en), .pc_wr_data(pc_wr_data),
    .lr_wr_en(lr_wr_en), .lr_wr_data(lr_wr_data), .flush(flush), .done(done),
    .taken(taken), .fault(fault)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic cc_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && n == v;
      4'hD: return z || n != v;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
  task automatic scramble();
    br_type = 2'($urandom); cond = 4'($urandom); flags_nzcv = 4'($urandom);
    offset = $urandom; rm_val = $urandom; cur_pc = $urandom;
  endtask
  task automatic run_br(input string tag, input logic [1:0] t, input logic [3:0] c, input logic [3:0] f,
                        input logic [31:0] o, input logic [31:0] r, input logic [31:0] p);
    logic tk, flt, go;
    int lat, pcc, w;
    logic [31:0] tgt;
    int first_done, n_done, n_pc, pc_cyc, n_lr, lr_cyc, n_flush, first_flush, n_fault, overlap;
    logic [31:0] pc_data, lr_data;
    logic tk_obs, flt_obs;
    tk = t != 2'd1 || cc_ok(c, f);
    flt = t == 2'd3 && !r[0];
    go = tk && !flt;
    lat = !go ? 2 : (t == 2'd2 ? 4 : 3) + F;
    pcc = t == 2'd2 ? 3 : 2;
    tgt = t == 2'd3 ? r : p + o;
    tgt[0] = 1'b0;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    br_type = t; cond = c; flags_nzcv = f; offset = o; rm_val = r; cur_pc = p; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    scramble();
    first_done = 0; n_done = 0; n_pc = 0; pc_cyc = 0; n_lr = 0; lr_cyc = 0;
    n_flush = 0; first_flush = 0; n_fault = 0; overlap = 0;
    pc_data = '0; lr_data = '0; tk_obs = 1'b0; flt_obs = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (done) begin n_done++; if (first_done == 0) begin first_done = k; tk_obs = taken; flt_obs = fault; end end
      if (pc_wr_en) begin n_pc++; pc_cyc = k; pc_data = pc_wr_data; end
      if (lr_wr_en) begin n_lr++; lr_cyc = k; lr_data = lr_wr_data; end
      if (flush) begin n_flush++; if (first_flush == 0) first_flush = k; end
      if (fault) n_fault++;
      if (pc_wr_en && lr_wr_en) overlap++;
    end
    check({tag, "_done_cyc"}, 32'(first_done), 32'(lat));
    check({tag, "_n_done"}, 32'(n_done), 32'd1);
    check({tag, "_taken"}, 32'(tk_obs), 32'(tk));
    check({tag, "_fault"}, 32'(flt_obs), 32'(flt));
    check({tag, "_n_fault"}, 32'(n_fault), 32'(flt));
    check({tag, "_n_pc"}, 32'(n_pc), 32'(go));
    check({tag, "_n_lr"}, 32'(n_lr), 32'(go && t == 2'd2));
    check({tag, "_n_flush"}, 32'(n_flush), go ? 32'(F) : 32'd0);
    check({tag, "_overlap"}, 32'(overlap), 32'd0);
    if (go) begin
      check({tag, "_pc_cyc"}, 32'(pc_cyc), 32'(pcc));
      check({tag, "_pc_data"}, pc_data, tgt);
      check({tag, "_flush_cyc"}, 32'(first_flush), 32'(pcc + 1));
    end
    if (go && t == 2'd2) begin
      check({tag, "_lr_cyc"}, 32'(lr_cyc), 32'd2);
      check({tag, "_lr_data"}, lr_data, p | 32'h1);
    end
  endtask
  initial begin
    int n_done, n_pc, first_done, second_done, lr_first, pc2_cyc;
    logic [31:0] pc2_data, lr_d;
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_strobes", {26'd0, pc_wr_en, lr_wr_en, flush, done, taken, fault}, 32'd0);
    check("rst_pc_data", pc_wr_data, 32'd0);
    check("rst_lr_data", lr_wr_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_br("b", 2'd0, 4'h0, 4'h0, 32'hFFFFFFF0, 32'h0, 32'h100);
    run_br("bcc_eq_nt", 2'd1, 4'h0, 4'b0000, 32'h40, 32'h0, 32'h100);
    run_br("bcc_eq_t", 2'd1, 4'h0, 4'b0100, 32'h40, 32'h0, 32'h100);
    run_br("bl", 2'd2, 4'h0, 4'h0, 32'h400, 32'h0, 32'h2000);
    run_br("bx", 2'd3, 4'h0, 4'h0, 32'h0, 32'h3001, 32'h500);
    run_br("bx_fault", 2'd3, 4'h0, 4'h0, 32'h0, 32'h3000, 32'h500);
    run_br("wrap", 2'd0, 4'h0, 4'h0, 32'h8, 32'h0, 32'hFFFFFFFC);
    run_br("bcc_al", 2'd1, 4'hE, 4'h0, 32'h20, 32'h0, 32'h1000);
    run_br("bcc_nv", 2'd1, 4'hF, 4'hF, 32'h20, 32'h0, 32'h1000);
    run_br("bcc_gt", 2'd1, 4'hC, 4'b1001, 32'h12, 32'h0, 32'h800);
    for (int i = 0; i < 40; i++)
      run_br("rand", 2'($urandom), 4'($urandom), 4'($urandom), $urandom, $urandom, $urandom);
    @(negedge clk);
    br_type = 2'd0; cond = 4'h0; offset = 32'h40; cur_pc = 32'h100; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("rstmid_flush_before", 32'(flush), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_flush_drop", 32'(flush), 32'd0);
    check("rstmid_ready", 32'(req_ready), 32'd1);
    check("rstmid_pc_data", pc_wr_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0; n_pc = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
      if (pc_wr_en || lr_wr_en) n_pc++;
    end
    check("rstmid_no_done", 32'(n_done), 32'd0);
    check("rstmid_no_write", 32'(n_pc), 32'd0);
    @(negedge clk);
    br_type = 2'd0; cond = 4'h0; offset = 32'hFFFFFFF0; rm_val = 32'h0; cur_pc = 32'h100; req_valid = 1'b1;
    @(posedge clk);
    #1 br_type = 2'd2; offset = 32'h400; cur_pc = 32'h2000;
    first_done = 0; second_done = 0; lr_first = 0; pc2_cyc = 0; pc2_data = '0; lr_d = '0; n_done = 0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      if (k == 6) req_valid = 1'b0;
      if (done) begin n_done++; if (first_done == 0) first_done = k; else second_done = k; end
      if (lr_wr_en && lr_first == 0) begin lr_first = k; lr_d = lr_wr_data; end
      if (pc_wr_en && k > 2) begin pc2_cyc = k; pc2_data = pc_wr_data; end
    end
    check("hold_first_done", 32'(first_done), 32'd5);
    check("hold_lr_cyc", 32'(lr_first), 32'd8);
    check("hold_lr_data", lr_d, 32'h2001);
    check("hold_pc_cyc", 32'(pc2_cyc), 32'd9);
    check("hold_pc_data", pc2_data, 32'h2400);
    check("hold_second_done", 32'(second_done), 32'd12);
    check("hold_n_done", 32'(n_done), 32'd2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
